pyjamask96_feeder: RTL and testbench
====================================

Name: pyjamask96_feeder

Overview:
- Upstream stage of the Pyjamask-96 byte-serial core.
- Accepts one 96-bit plaintext block and one 128-bit key through a valid/ready handshake.
- Serialises both words MSB-byte-first onto the core's byte_in / byte_key_in lanes, drives the core's load and start strobes, then holds off the next block until the core has finished emitting its ciphertext bytes.

Parameters:
- WAIT_MAX, 256, max cycles spent in WAIT before aborting with err; range 32..65535.
- CNT_W, 16, width of the wait/timeout counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  host presents pt/key.
- in_ready  out  1  feeder can accept a block.
- pt  in  96  plaintext block; bit 95 is the MSB of byte 0.
- key  in  128  key; bit 127 is the MSB of byte 0.
- core_load  out  1  one-cycle strobe marking byte 0 on the lanes.
- core_start  out  1  one-cycle strobe after the last key byte.
- core_byte  out  8  plaintext byte lane.
- core_key_byte  out  8  key byte lane.
- core_valid  in  1  core output-valid (ciphertext byte strobe).
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on WAIT timeout.

Behaviour:
- Reset: asynchronous, active-high. Forces state=IDLE, byte counter=0, wait counter=0, seen_valid=0, pt/key holding regs=0. All outputs 0, except in_ready=1 once reset deasserts. Reset during any state aborts the block; no partial strobes follow.
- Handshake: a block is accepted on a clk edge with in_valid & in_ready. pt and key are registered on that edge and ignored afterwards. in_ready = (state==IDLE), a registered decode with no combinational path from in_valid.
- States: IDLE -> LOAD -> START -> WAIT -> IDLE.
- IDLE:
  - All core outputs are 0.
  - On accept: byte counter k=0, go to LOAD.
- LOAD (16 cycles, k=0..15):
  - core_key_byte = key_reg[127-8k -: 8].
  - core_byte = pt_reg[95-8k -: 8] for k<=11; 8'h00 for k=12..15.
  - core_load=1 only when k=0.
  - k increments each cycle. At k=15, go to START.
  - Accept-to-first-byte latency is 1 cycle: byte 0 is visible in the cycle after the accepting edge.
- START (1 cycle): core_start=1, lanes 0, wait counter cleared, seen_valid cleared, go to WAIT.
- WAIT:
  - Wait counter increments every cycle.
  - core_valid=1 sets seen_valid.
  - Completion: seen_valid & !core_valid (falling edge of the ciphertext burst) -> IDLE. in_ready rises the next cycle.
  - Timeout: wait counter == WAIT_MAX-1 without completion -> err=1 for one cycle, go to IDLE.
  - If completion and timeout fall in the same cycle, completion wins and err stays 0.
- Core strobes: core_load and core_start are never high together, and are never high outside LOAD k=0 and START respectively.
- in_valid while busy: ignored (in_ready=0). Host must hold pt/key stable until accepted.
- Counter widths: k is 4 bits and wraps only via the state exit; the wait counter saturates, never wraps.
- Throughput: 18 cycles + core latency per block. No pipelining across blocks.

Decomposition:
- Shared package pyjamask_pkg holds:
  - Block width 96, key width 128.
  - Byte counts: PT_BYTES=12, KEY_BYTES=16.
  - State encoding for the feeder FSM.
- Sub-module pyjamask_byte_mux: combinational byte select of pt_reg/key_reg by k, including zero padding for k>=12. Everything else stays in the top.

Test Plan:
- Reset then single block, pt=96'h00112233_44556677_8899aabb, key=128'h000102..0f:
  - core_load high for exactly one cycle with core_byte=8'h00, core_key_byte=8'h00.
  - Cycle k=11 shows core_byte=8'hbb, core_key_byte=8'h0b.
  - k=12..15 show core_byte=8'h00, core_key_byte=8'h0c..0f.
  - core_start is high in cycle 17 after accept.
- WAIT completion: a model drives core_valid high for 12 cycles starting 60 cycles after core_start, then low -> in_ready=1 exactly 2 cycles after core_valid falls; err stays 0.
- Timeout, WAIT_MAX=64, core_valid never asserted -> err pulses once, 64 cycles after entering WAIT; state returns to IDLE; in_ready=1 on the next cycle.
- Back-to-back: in_valid held high with a second block queued -> second accept occurs only after the first WAIT completes; no core_load during WAIT; second block bytes are correct.
- Reset asserted at LOAD k=7 -> all outputs 0 immediately (asynchronous); no core_start ever seen; after release, a fresh block is accepted and serialised correctly from byte 0.
- Simultaneous completion and timeout, with core_valid falling in the cycle the counter hits WAIT_MAX-1 -> exit to IDLE with err=0.

Source files
------------

// File: rtl/pyjamask_pkg.sv
// Shared definitions for the Pyjamask-96 feeder.
// Holds the block and key widths, their byte counts, and the state
// encoding of the feeder FSM. No ports; imported by the feeder files.
package pyjamask_pkg;

  localparam int PT_W      = 96;
  localparam int KEY_W     = 128;
  localparam int PT_BYTES  = 12;
  localparam int KEY_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/pyjamask_byte_mux.sv
// Combinational byte selector for the feeder's two lanes.
// Picks byte k (MSB byte first) of the held plaintext and key. The
// plaintext lane pads with zeros for k >= 12, because the key has four
// more bytes than the block.
// Ports:
//   pt_i       - held 96-bit plaintext
//   key_i      - held 128-bit key
//   k_i        - byte index 0..15
//   en_i       - lanes are driven only when high, else both are 0
//   pt_byte_o  - selected plaintext byte
//   key_byte_o - selected key byte
module pyjamask_byte_mux
  import pyjamask_pkg::*;
(
  input  logic [PT_W-1:0]  pt_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [3:0]       k_i,
  input  logic             en_i,
  output logic [7:0]       pt_byte_o,
  output logic [7:0]       key_byte_o
);

  always_comb begin
    pt_byte_o  = 8'h00;
    key_byte_o = 8'h00;
    if (en_i) begin
      for (int i = 0; i < KEY_BYTES; i++) begin
        if (k_i == 4'(i)) key_byte_o = key_i[KEY_W-1-8*i -: 8];
      end
      for (int i = 0; i < PT_BYTES; i++) begin
        if (k_i == 4'(i)) pt_byte_o = pt_i[PT_W-1-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/pyjamask96_feeder.sv
// Upstream feeder for the byte-serial Pyjamask-96 core.
// Accepts one plaintext/key pair through a valid/ready handshake. It
// streams both words MSB byte first over 16 cycles, with core_load on
// byte 0, then pulses core_start. It then waits for the core's
// ciphertext burst to end before it takes the next block. It gives up
// with a one-cycle err pulse if the burst does not end within WAIT_MAX
// cycles.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   in_valid / in_ready - host handshake; pt/key are sampled on accept
//   pt, key             - 96-bit plaintext, 128-bit key
//   core_load           - strobe marking byte 0 on the lanes
//   core_start          - strobe in the cycle after the last key byte
//   core_byte           - plaintext byte lane
//   core_key_byte       - key byte lane
//   core_valid          - ciphertext byte strobe from the core
//   busy                - feeder is not idle
//   err                 - one-cycle pulse on wait timeout
module pyjamask96_feeder
  import pyjamask_pkg::*;
#(
  parameter int WAIT_MAX = 256,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PT_W-1:0]  pt,
  input  logic [KEY_W-1:0] key,
  output logic             core_load,
  output logic             core_start,
  output logic [7:0]       core_byte,
  output logic [7:0]       core_key_byte,
  input  logic             core_valid,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  feeder_state_e    state_q;
  logic [3:0]       k_q;
  logic [CNT_W-1:0] cnt_q;
  logic             seen_q;
  logic             rdy_q;
  logic [PT_W-1:0]  pt_q;
  logic [KEY_W-1:0] key_q;

  logic done;
  logic timeout;

  // Completion is the falling edge of the ciphertext burst. It has
  // priority over a timeout that lands in the same cycle.
  assign done    = seen_q & ~core_valid;
  assign timeout = (cnt_q >= WAIT_LAST);

  // rdy_q mirrors (state_q == ST_IDLE). It is held low during reset and
  // rises on the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= 4'd0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      rdy_q   <= 1'b0;
      pt_q    <= '0;
      key_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rdy_q <= 1'b1;
          if (in_valid && rdy_q) begin
            pt_q    <= pt;
            key_q   <= key;
            k_q     <= 4'd0;
            rdy_q   <= 1'b0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          k_q <= k_q + 4'd1;
          if (k_q == 4'd15) state_q <= ST_START;
        end
        ST_START: begin
          cnt_q   <= '0;
          seen_q  <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
          seen_q <= seen_q | core_valid;
          if (done || timeout) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = rdy_q;
  assign busy       = (state_q != ST_IDLE);
  assign core_load  = (state_q == ST_LOAD) && (k_q == 4'd0);
  assign core_start = (state_q == ST_START);
  assign err        = (state_q == ST_WAIT) && timeout && !done;

  pyjamask_byte_mux u_mux (
    .pt_i       (pt_q),
    .key_i      (key_q),
    .k_i        (k_q),
    .en_i       (state_q == ST_LOAD),
    .pt_byte_o  (core_byte),
    .key_byte_o (core_key_byte)
  );

endmodule

// File: tb/tb_pyjamask96_feeder.sv
`timescale 1ns/1ps
module tb_pyjamask96_feeder;

  localparam logic [95:0]  P1 = 96'h00112233_44556677_8899aabb;
  localparam logic [127:0] K1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [95:0]  P2 = 96'hdeadbeef_01234567_89abcdef;
  localparam logic [127:0] K2 = 128'hffeeddcc_bbaa9988_77665544_33221100;
  localparam logic [95:0]  P3 = 96'h5a5a5a5a_a5a5a5a5_0f1e2d3c;
  localparam logic [127:0] K3 = 128'h13579bdf_2468ace0_fedcba98_76543210;

  logic clk = 1'b0;
  logic reset;
  logic [95:0]  pt;
  logic [127:0] key;

  logic a_valid, a_rdy, a_load, a_start, a_cv, a_busy, a_err;
  logic [7:0] a_byte, a_kbyte;
  logic b_valid, b_rdy, b_load, b_start, b_cv, b_busy, b_err;
  logic [7:0] b_byte, b_kbyte;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pyjamask96_feeder #(.WAIT_MAX(256), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_rdy),
    .pt(pt), .key(key), .core_load(a_load), .core_start(a_start),
    .core_byte(a_byte), .core_key_byte(a_kbyte), .core_valid(a_cv),
    .busy(a_busy), .err(a_err)
  );

  pyjamask96_feeder #(.WAIT_MAX(64), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_rdy),
    .pt(pt), .key(key), .core_load(b_load), .core_start(b_start),
    .core_byte(b_byte), .core_key_byte(b_kbyte), .core_valid(b_cv),
    .busy(b_busy), .err(b_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Starts in the first LOAD cycle of dut_a; returns in its START cycle.
  task automatic serial_a(input logic [95:0] p, input logic [127:0] k);
    logic [7:0] ep, ek;
    for (int i = 0; i < 16; i++) begin
      ek = 8'(k >> (8 * (15 - i)));
      ep = (i < 12) ? 8'(p >> (8 * (11 - i))) : 8'h00;
      chk($sformatf("load_k%0d", i), a_load, (i == 0));
      chk($sformatf("start_k%0d", i), a_start, 1'b0);
      chk($sformatf("pbyte_k%0d", i), a_byte, ep);
      chk($sformatf("kbyte_k%0d", i), a_kbyte, ek);
      chk($sformatf("rdy_k%0d", i), a_rdy, 1'b0);
      step();
    end
    chk("start_pulse", a_start, 1'b1);
    chk("start_no_load", a_load, 1'b0);
    chk("start_pbyte", a_byte, 8'h00);
    chk("start_kbyte", a_kbyte, 8'h00);
  endtask

  // Drives a ciphertext burst on dut_a, counted in cycles after START.
  task automatic wait_a(input int st, input int len, input int idle_at, input int last);
    int loads;
    int errs;
    loads = 0;
    errs  = 0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      a_cv = (c >= st && c < st + len);
      #1;
      chk($sformatf("wait_rdy_c%0d", c), a_rdy, (c >= idle_at));
      if (a_load) loads++;
      if (a_err) errs++;
    end
    a_cv = 1'b0;
    chk("wait_no_load", loads, 0);
    chk("wait_no_err", errs, 0);
  endtask

  // Hands a block to dut_b; returns in its START cycle.
  task automatic b_send();
    int got;
    int loads;
    got   = 0;
    loads = 0;
    b_valid = 1'b1;
    for (int i = 0; i < 40 && got == 0; i++) begin
      step();
      if (b_busy) b_valid = 1'b0;
      if (b_load) loads++;
      if (b_start) got = 1;
    end
    b_valid = 1'b0;
    chk("b_start_seen", got, 1);
    chk("b_load_once", loads, 1);
  endtask

  initial begin
    int errs, first, starts, loads;
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_cv = 1'b0; b_cv = 1'b0;
    pt = '0; key = '0;
    step(); step();
    chk("rst_rdy", a_rdy, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_load", a_load, 1'b0);
    chk("rst_start", a_start, 1'b0);
    chk("rst_pbyte", a_byte, 8'h00);
    chk("rst_kbyte", a_kbyte, 8'h00);
    chk("rst_err", a_err, 1'b0);
    chk("rst_b_rdy", b_rdy, 1'b0);
    reset = 1'b0;
    step();
    chk("post_rst_rdy", a_rdy, 1'b1);
    chk("post_rst_b_rdy", b_rdy, 1'b1);
    chk("post_rst_busy", a_busy, 1'b0);

    // Single block, then a burst of 12 starting 60 cycles after START.
    pt = P1; key = K1; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    chk("accept_busy", a_busy, 1'b1);
    serial_a(P1, K1);
    wait_a(60, 12, 73, 75);

    // Back-to-back: in_valid stays high with the next block queued.
    pt = P2; key = K2; a_valid = 1'b1;
    step();
    pt = P3; key = K3;
    serial_a(P2, K2);
    wait_a(5, 3, 9, 9);
    step();
    a_valid = 1'b0;
    chk("b2b_second_accept", a_busy, 1'b1);
    serial_a(P3, K3);
    wait_a(2, 1, 4, 5);

    // Reset in the middle of LOAD, at k = 7.
    pt = P1; key = K1; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    repeat (7) step();
    chk("k7_pbyte", a_byte, 8'h77);
    chk("k7_kbyte", a_kbyte, 8'h07);
    reset = 1'b1;
    #1;
    chk("arst_busy", a_busy, 1'b0);
    chk("arst_rdy", a_rdy, 1'b0);
    chk("arst_pbyte", a_byte, 8'h00);
    chk("arst_kbyte", a_kbyte, 8'h00);
    chk("arst_load", a_load, 1'b0);
    chk("arst_start", a_start, 1'b0);
    starts = 0;
    loads  = 0;
    repeat (3) begin
      step();
      if (a_start) starts++;
    end
    reset = 1'b0;
    repeat (20) begin
      step();
      if (a_start) starts++;
      if (a_load) loads++;
    end
    chk("arst_no_start", starts, 0);
    chk("arst_no_load", loads, 0);
    chk("arst_rdy_back", a_rdy, 1'b1);
    pt = P2; key = K2; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    serial_a(P2, K2);
    wait_a(3, 2, 6, 6);

    // Timeout with WAIT_MAX = 64 and no ciphertext burst.
    pt = P3; key = K3;
    b_send();
    errs  = 0;
    first = 0;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (b_err) begin
        errs++;
        if (first == 0) first = c;
      end
      if (c == 64) chk("to_rdy_at_err", b_rdy, 1'b0);
      if (c == 65) begin
        chk("to_rdy_next", b_rdy, 1'b1);
        chk("to_busy_next", b_busy, 1'b0);
      end
    end
    chk("to_err_count", errs, 1);
    chk("to_err_cycle", first, 64);

    // Burst falls in the same cycle the counter reaches WAIT_MAX-1.
    b_send();
    errs = 0;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      b_cv = (c >= 60 && c <= 63);
      #1;
      if (b_err) errs++;
      if (c == 64) chk("sim_rdy_c64", b_rdy, 1'b0);
      if (c == 65) begin
        chk("sim_rdy_c65", b_rdy, 1'b1);
        chk("sim_busy_c65", b_busy, 1'b0);
      end
    end
    b_cv = 1'b0;
    chk("sim_no_err", errs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
